// File: rtl/cache_pkg.sv
// Shared types and constants for the L1-to-L2 port arbitration slice.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == REQ_D) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Requester-side and L2-side signals of the shared L2 port arbiter.
interface l2_port_arbiter_if import cache_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              l2_req;
    logic              l2_we;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_wdata;
    logic              l2_ack;
    logic [DATA_W-1:0] l2_rdata;

    modport master (
        input  req, we, addr0, addr1, wdata0, wdata1, l2_ack, l2_rdata,
        output done, rdata, err, busy, l2_req, l2_we, l2_addr, l2_wdata
    );

    modport slave (
        output req, we, addr0, addr1, wdata0, wdata1, l2_ack, l2_rdata,
        input  done, rdata, err, busy, l2_req, l2_we, l2_addr, l2_wdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin owner select.
module rr_pick2 import cache_pkg::*; (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       valid,
    output logic       owner
);

    always_comb begin
        valid = |req;
        // rr only matters on contention; a lone request always wins
        if (req == 2'b11) begin
            owner = rr;
        end else begin
            owner = req[REQ_D] ? REQ_D : REQ_I;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between instruction and data L1s: round-robin grant,
// hold-until-ack issue with timeout, one-cycle done pulse to the owner.
module l2_port_arbiter import cache_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    l2_port_arbiter_if.master bus
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t        state, state_n;
    logic              rr;
    logic              owner;
    logic              pick_valid;
    logic              pick_owner;
    logic [CW-1:0]     cnt;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    rr_pick2 u_pick (
        .req   (bus.req),
        .rr    (rr),
        .valid (pick_valid),
        .owner (pick_owner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = ISSUE;
            ISSUE:   if (bus.l2_ack || cnt == CNT_LAST) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr        <= REQ_I;
            owner     <= REQ_I;
            cnt       <= '0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_owner;
                        cmd_we    <= bus.we[pick_owner];
                        cmd_addr  <= pick_owner ? bus.addr1 : bus.addr0;
                        cmd_wdata <= pick_owner ? bus.wdata1 : bus.wdata0;
                        cnt       <= '0;
                    end
                end
                ISSUE: begin
                    // ack is tested first so an ack on the limit cycle still succeeds
                    if (bus.l2_ack) begin
                        rdata_q <= cmd_we ? '0 : bus.l2_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: rr <= ~owner;
                default: ;
            endcase
        end
    end

    assign bus.done     = (state == RESP) ? owner_onehot(owner) : '0;
    assign bus.rdata    = rdata_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state != IDLE);
    assign bus.l2_req   = (state == ISSUE);
    assign bus.l2_we    = cmd_we;
    assign bus.l2_addr  = cmd_addr;
    assign bus.l2_wdata = cmd_wdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: expected completions queued at request time.
module tb_l2_port_arbiter;

    localparam int TMO = 4;

    typedef struct {
        logic [1:0]  done;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          issue_len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    l2_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    l2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: command checked every ISSUE cycle, completion popped on done.
    logic mon_prev_req = 1'b0;
    int   mon_hi = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_hi = 0;
            end else begin
                if (bus.l2_req && sb.size() > 0) begin
                    check_eq("l2_addr", bus.l2_addr, sb[0].addr);
                    check_eq("l2_we", bus.l2_we, sb[0].we);
                    check_eq("l2_wdata", bus.l2_wdata, sb[0].wdata);
                end
                if (bus.l2_req) mon_hi++;
                if (bus.done != 2'b00) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_done", bus.done, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        check_eq("done", bus.done, e.done);
                        check_eq("rdata", bus.rdata, e.rdata);
                        check_eq("err", bus.err, e.err);
                        check_eq("l2_req_cycles", mon_hi, e.issue_len);
                    end
                    mon_hi = 0;
                end
            end
        end
    end

    task automatic serve(input int ack_cycle, input logic [31:0] rd, input bit perturb);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.l2_req;
        end
        check_eq("l2_req_rise", seen, 1'b1);
        if (perturb) begin
            bus.addr0  = ~bus.addr0;
            bus.addr1  = ~bus.addr1;
            bus.wdata0 = ~bus.wdata0;
            bus.wdata1 = ~bus.wdata1;
            bus.we     = ~bus.we;
        end
        if (ack_cycle >= 1 && ack_cycle <= TMO) begin
            repeat (ack_cycle - 1) begin @(posedge clk); #1; end
            bus.l2_ack   = 1'b1;
            bus.l2_rdata = rd;
            @(posedge clk); #1;
            bus.l2_ack   = 1'b0;
            bus.l2_rdata = $urandom;
        end
    endtask

    task automatic wait_done(output int t);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.done != 2'b00) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_eq("done_seen", got, 1'b1);
        t = cyc;
    endtask

    function automatic exp_t mk_exp(input logic own, input logic we, input logic [31:0] a,
                                    input logic [31:0] d, input int ack_cycle, input logic [31:0] rd);
        exp_t e;
        bit acked = (ack_cycle >= 1 && ack_cycle <= TMO);
        e.done      = own ? 2'b10 : 2'b01;
        e.we        = we;
        e.addr      = a;
        e.wdata     = d;
        e.err       = !acked;
        e.rdata     = (acked && !we) ? rd : 32'h0;
        e.issue_len = acked ? ack_cycle : TMO;
        return e;
    endfunction

    // Caller is at posedge+#1 of an IDLE cycle.
    task automatic txn(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0, a1,
                       input logic [31:0] d0, d1, input int ack_cycle, input logic [31:0] rd,
                       input logic own, input bit perturb);
        exp_t e;
        int t0, t;
        e = mk_exp(own, w[own], own ? a1 : a0, own ? d1 : d0, ack_cycle, rd);
        sb.push_back(e);
        bus.we = w; bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
        bus.req = r;
        t0 = cyc;
        serve(ack_cycle, rd, perturb);
        wait_done(t);
        check_eq("latency", t - t0, e.issue_len + 1);
        bus.req = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t, tp;
        bus.req = '0; bus.we = '0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0; bus.l2_ack = 1'b0; bus.l2_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", bus.done, 2'b00);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_l2_req", bus.l2_req, 1'b0);
        check_eq("rst_l2_addr", bus.l2_addr, 32'h0);
        check_eq("rst_l2_we", bus.l2_we, 1'b0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Contention from reset: both held, immediate acks, grants 0,1,0,1.
        bus.addr0 = 32'h10; bus.addr1 = 32'h20; bus.we = 2'b00;
        for (int i = 0; i < 4; i++)
            sb.push_back(mk_exp(i[0], 1'b0, i[0] ? 32'h20 : 32'h10, 32'h0, 1, 32'h1111_0000 + i));
        bus.req = 2'b11;
        t0 = cyc; tp = t0;
        for (int i = 0; i < 4; i++) begin
            serve(1, 32'h1111_0000 + i, 1'b0);
            wait_done(t);
            check_eq(i == 0 ? "cont_latency" : "cont_gap", t - tp, i == 0 ? 2 : 3);
            tp = t;
        end
        bus.req = 2'b00;
        @(posedge clk); #1;

        // Single read, ack on the 4th (limit) ISSUE cycle, inputs perturbed mid-ISSUE.
        txn(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 4, 32'hDEAD_BEEF, 1'b0, 1'b1);
        @(posedge clk); #1;

        // Write from the data side, ack in the first ISSUE cycle.
        txn(2'b10, 2'b10, 32'h0, 32'h80, 32'h0, 32'h1234, 1, 32'h5555_AAAA, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Timeout, then an ack during RESP and IDLE must be ignored.
        txn(2'b01, 2'b00, 32'h44, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        bus.l2_ack = 1'b1; bus.l2_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        check_eq("late_ack_busy0", bus.busy, 1'b0);
        @(posedge clk); #1;
        check_eq("late_ack_busy1", bus.busy, 1'b0);
        check_eq("late_ack_l2_req", bus.l2_req, 1'b0);
        bus.l2_ack = 1'b0;
        @(posedge clk); #1;

        // Mid-window ack, then an instruction-side read to leave rr pointing at 1.
        txn(2'b10, 2'b00, 32'h0, 32'h64, 32'h0, 32'h0, 2, 32'hCAFE_F00D, 1'b1, 1'b0);
        @(posedge clk); #1;
        txn(2'b01, 2'b00, 32'h48, 32'h0, 32'h0, 32'h0, 3, 32'h0123_4567, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Reset mid-ISSUE: immediate deassert, no done; restart uses rr=0.
        bus.addr0 = 32'h10; bus.addr1 = 32'h99; bus.we = 2'b00;
        bus.req = 2'b11;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(posedge clk); #1;
                seen = bus.l2_req;
            end
            check_eq("pre_rst_l2_req", seen, 1'b1);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_l2_req", bus.l2_req, 1'b0);
        check_eq("async_rst_busy", bus.busy, 1'b0);
        check_eq("async_rst_done", bus.done, 2'b00);
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h0BAD_F00D));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        t0 = cyc;
        serve(1, 32'h0BAD_F00D, 1'b0);
        wait_done(t);
        check_eq("post_rst_latency", t - t0, 2);
        bus.req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Shares the single L2 cache port between two L1 requesters: port 0 is the instruction-side L1, port 1 the data-side L1. It selects one requester using round-robin priority and latches that request. It then drives the L2 port with a hold-until-ack handshake and returns read data plus a one-cycle completion pulse to the winning requester. A per-transaction timeout counter makes sure a missing L2 acknowledge cannot stall either requester forever.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, ISSUE cycles without l2_ack before the transaction completes with an error; must be ≥ 2

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  2  per-requester request; held stable with its command until that requester's done
- we  input  2  per-requester write enable (1 = write, 0 = read)
- addr0, addr1  input  ADDR_W  per-requester address
- wdata0, wdata1  input  DATA_W  per-requester write data
- done  output  2  one-hot, one-cycle completion pulse to the owning requester
- rdata  output  DATA_W  read data, valid while done is high
- err  output  1  timeout flag, valid while done is high
- busy  output  1  high in ISSUE and RESP
- l2_req  output  1  L2 request, held until ack or timeout
- l2_we, l2_addr, l2_wdata  output  1/ADDR_W/DATA_W  latched command
- l2_ack  input  1  one-cycle L2 acknowledge; l2_rdata is valid in the same cycle
- l2_rdata  input  DATA_W  L2 read data

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - If req is nonzero: pick the owner, latch owner/we/addr/wdata, clear the counter, go to ISSUE.
  - Otherwise stay in IDLE.
- Owner selection:
  - Only one req bit set: that requester wins.
  - Both set: the requester indicated by the round-robin pointer rr wins.
- ISSUE:
  - l2_req=1 and the latched command is driven on l2_we/l2_addr/l2_wdata.
  - l2_ack=1: capture l2_rdata (or 0 if the command is a write), err_n=0, go to RESP.
  - No ack and counter = TIMEOUT-1: rdata_n=0, err_n=1, go to RESP.
  - Otherwise: increment the counter.
- RESP:
  - done[owner]=1, rdata and err are driven from registers.
  - Set rr = ~owner, go to IDLE.
- Requesters drop req on the clock edge where they see done. A req still high in the next IDLE cycle is treated as a new request.
- Outputs are all registered or decoded from state. No combinational path from req or l2_ack to any output.
- Arithmetic:
  - Counter width is $clog2(TIMEOUT).
  - The counter saturates; it is never compared beyond TIMEOUT-1.
- Reset values: state=IDLE, rr=0, counter=0, done=0, rdata=0, err=0, busy=0, l2_req=0, and l2_we/l2_addr/l2_wdata all 0.

## Timing
- Cycle numbering: req first seen in IDLE at cycle N.
  - N+1: ISSUE, l2_req=1.
  - Ack at cycle N+k (k≥1): RESP at N+k+1, done at N+k+1.
- Minimum request-to-done latency is 2 cycles. Maximum throughput is one transaction per 3 cycles.
- Timeout: with no ack, done/err assert at cycle N+TIMEOUT+1.
- Boundary conditions:
  - l2_ack in the final ISSUE cycle (same cycle as the timeout limit): the ack wins and err=0.
  - l2_ack outside ISSUE (IDLE or RESP): ignored, no state change.
  - req changes during ISSUE: ignored, because the command is latched.
  - The non-owner's req is held pending with no loss. It wins in the IDLE cycle after RESP, because rr now points to it.
  - Reset mid-transaction: asynchronously forces IDLE and deasserts l2_req/done/busy; the transaction is dropped with no done pulse.

## Structure
- Shared package cache_pkg holds:
  - the state typedef (IDLE, ISSUE, RESP)
  - default ADDR_W/DATA_W constants
  - requester index constants (REQ_I=0, REQ_D=1)
- One sub-module, rr_pick2: combinational 2-way round-robin select. Inputs: req[1:0] and rr. Outputs: valid and the owner index.
- The FSM, the counter, and the command/response registers stay in l2_port_arbiter.

## Test plan
- Single read:
  - Stimulus: req=01, we=00, addr0=0x40; l2_ack pulses 3 cycles after l2_req rises with l2_rdata=0xDEADBEEF.
  - Required: l2_addr=0x40; done=01 one cycle later; rdata=0xDEADBEEF; err=0.
- Contention:
  - Stimulus: req=11 from reset; addr0=0x10, addr1=0x20; immediate acks.
  - Required: first grant is requester 0 (l2_addr=0x10), then requester 1 (0x20) with no idle gap beyond the IDLE cycle. With both held continuously, the grants alternate 0,1,0,1.
- Write:
  - Stimulus: req=10, we=10, addr1=0x80, wdata1=0x1234; ack in the first ISSUE cycle.
  - Required: l2_we=1, l2_wdata=0x1234; done=10 at N+2; rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Required: l2_req high for exactly 4 cycles; done with err=1 and rdata=0 at N+5. A late ack afterward is ignored.
- Ack on the limit cycle:
  - Stimulus: ack in the 4th ISSUE cycle with TIMEOUT=4.
  - Required: err=0, rdata = l2_rdata.
- Reset mid-ISSUE:
  - Stimulus: assert rst during ISSUE.
  - Required: l2_req=0 and busy=0 immediately, without waiting for a clock edge; no done pulse. After release, a pending req restarts from IDLE with rr=0.
